// File: rtl/ssd_scan_if.sv
// ssd_scan_if: producer-side bus of the seven-segment scan driver (digits, load strobe, status).
// blink_mask exists only when SSD_BLINK_EN is defined.
interface ssd_scan_if;
   logic        enable;
   logic [15:0] digits;
   logic [3:0]  digit_en;
   logic [3:0]  dp_in;
   logic        load;
`ifdef SSD_BLINK_EN
   logic [3:0]  blink_mask;
`endif
   logic        pending;
   logic        frame_tick;

   modport master (
      output enable, digits, digit_en, dp_in, load,
`ifdef SSD_BLINK_EN
      output blink_mask,
`endif
      input  pending, frame_tick
   );

   modport slave (
      input  enable, digits, digit_en, dp_in, load,
`ifdef SSD_BLINK_EN
      input  blink_mask,
`endif
      output pending, frame_tick
   );
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: four-digit multiplexed seven-segment driver with a tear-free shadow load.
// Define SSD_BLINK_EN to add per-digit blinking (blink_mask, BLINK_DIV).
module ssd_scan_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   ssd_scan_if.slave   bus,
   output logic [6:0]  ssd_cathode,
   output logic        ssd_dp,
   output logic [3:0]  ssd_anode
);
   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  en;
      logic [3:0]  dp;
`ifdef SSD_BLINK_EN
      logic [3:0]  mask;
`endif
   } disp_t;

   localparam logic [23:0] TC = 24'(REFRESH_DIV - 1);

   disp_t       shadow_q, shadow_d, active_q, active_d, load_val;
   logic [23:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic        pending_q, pending_d, tick_q, tick_d, dp_q, dp_d;
   logic [6:0]  cath_q, cath_d;
   logic [3:0]  anode_q, anode_d;
   logic [3:0]  nib;
   logic        tc, boundary, vis, hidden;

   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 7'b0000001;
         4'h1: seg7 = 7'b1001111;
         4'h2: seg7 = 7'b0010010;
         4'h3: seg7 = 7'b0000110;
         4'h4: seg7 = 7'b1001100;
         4'h5: seg7 = 7'b0100100;
         4'h6: seg7 = 7'b0100000;
         4'h7: seg7 = 7'b0001111;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0000100;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b1100000;
         4'hC: seg7 = 7'b0110001;
         4'hD: seg7 = 7'b1000010;
         4'hE: seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

`ifdef SSD_BLINK_EN
   localparam logic [31:0] BTC = 32'(BLINK_DIV - 1);
   logic [31:0] bcnt_q, bcnt_d;
   logic        phase_q, phase_d;

   always_comb begin
      bcnt_d  = bcnt_q == BTC ? '0 : bcnt_q + 32'd1;
      phase_d = bcnt_q == BTC ? ~phase_q : phase_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bcnt_q  <= '0;
         phase_q <= 1'b1;
      end else begin
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
      end
   end

   assign hidden   = ~phase_d & active_d.mask[idx_d];
   assign load_val = {bus.digits, bus.digit_en, bus.dp_in, bus.blink_mask};
`else
   assign hidden   = 1'b0;
   assign load_val = {bus.digits, bus.digit_en, bus.dp_in};
`endif

   // Outputs are computed from next-state so they land on the edge that advances the slot.
   always_comb begin
      tc        = bus.enable && cnt_q == TC;
      boundary  = tc && idx_q == 2'd3;
      cnt_d     = !bus.enable ? cnt_q : tc ? '0 : cnt_q + 24'd1;
      idx_d     = tc ? idx_q + 2'd1 : idx_q;
      shadow_d  = bus.load ? load_val : shadow_q;
      active_d  = boundary && pending_q ? shadow_q : active_q;
      pending_d = bus.load | (pending_q & ~boundary);
      tick_d    = boundary;
      nib       = active_d.dig[idx_d*4 +: 4];
      vis       = bus.enable && active_d.en[idx_d] && !hidden;
      anode_d   = vis ? ~(4'b0001 << idx_d) : 4'hF;
      cath_d    = vis ? seg7(nib) : 7'h7F;
      dp_d      = !(vis && active_d.dp[idx_d]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         tick_q    <= 1'b0;
         anode_q   <= 4'hF;
         cath_q    <= 7'h7F;
         dp_q      <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         tick_q    <= tick_d;
         anode_q   <= anode_d;
         cath_q    <= cath_d;
         dp_q      <= dp_d;
      end
   end

   assign ssd_anode      = anode_q;
   assign ssd_cathode    = cath_q;
   assign ssd_dp         = dp_q;
   assign bus.pending    = pending_q;
   assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: directed + random stimulus against a slot-position reference model.
module tb_ssd_scan_driver;
   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] ssd_cathode;
   logic       ssd_dp;
   logic [3:0] ssd_anode;

   ssd_scan_if bus();

   ssd_scan_driver #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .ssd_cathode(ssd_cathode), .ssd_dp(ssd_dp), .ssd_anode(ssd_anode)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   logic [6:0] seg_tab [16];

   // Model: pos counts enabled cycles since reset; slot and frame follow by division.
   int pos;
   logic pend;
   logic [15:0] sh_dig, ac_dig;
   logic [3:0]  sh_en, sh_dp, ac_en, ac_dp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      pos = 0; pend = 0;
      sh_dig = 0; sh_en = 0; sh_dp = 0;
      ac_dig = 0; ac_en = 0; ac_dp = 0;
   endtask

   task automatic step(input logic en, input logic ld, input logic [15:0] d,
                       input logic [3:0] de, input logic [3:0] dp);
      logic bnd, vis;
      int idx, dv;
      bus.enable = en; bus.load = ld; bus.digits = d; bus.digit_en = de; bus.dp_in = dp;
      @(posedge clk); #1;
      bnd = en && (pos % FRAME == FRAME - 1);
      if (bnd && pend) begin
         ac_dig = sh_dig; ac_en = sh_en; ac_dp = sh_dp; pend = 0;
      end
      if (ld) begin
         sh_dig = d; sh_en = de; sh_dp = dp; pend = 1;
      end
      if (en) pos++;
      idx = (pos / DIV) % 4;
      dv  = (int'(ac_dig) >> (4 * idx)) % 16;
      vis = en && ac_en[idx];
      check("anode", 32'(ssd_anode), vis ? 32'(15 - (1 << idx)) : 32'hF);
      check("cathode", 32'(ssd_cathode), vis ? 32'(seg_tab[dv]) : 32'h7F);
      check("dp", 32'(ssd_dp), vis ? 32'(!ac_dp[idx]) : 32'h1);
      check("pending", 32'(bus.pending), 32'(pend));
      check("frame_tick", 32'(bus.frame_tick), 32'(bnd));
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [3:0] de, input logic [3:0] dp);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, de, dp);
   endtask

   initial begin
      seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      bus.enable = 0; bus.load = 0; bus.digits = 0; bus.digit_en = 0; bus.dp_in = 0;
`ifdef SSD_BLINK_EN
      bus.blink_mask = 4'h0;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_anode", 32'(ssd_anode), 32'hF);
      check("rst_cathode", 32'(ssd_cathode), 32'h7F);
      check("rst_dp", 32'(ssd_dp), 32'h1);
      check("rst_pending", 32'(bus.pending), 32'h0);
      check("rst_tick", 32'(bus.frame_tick), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      step(1'b1, 1'b1, 16'h3210, 4'hF, 4'h0);
      idle(2 * FRAME, 4'h0, 4'h0);
      // Load mid-frame during slot 1.
      while ((pos / DIV) % 4 != 1) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      step(1'b1, 1'b1, 16'hABCD, 4'hF, 4'h0);
      idle(2 * FRAME, 4'h0, 4'h0);
      // Load coincident with a frame boundary.
      step(1'b1, 1'b1, 16'h5678, 4'hF, 4'h0);
      while (pos % FRAME != FRAME - 1) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      step(1'b1, 1'b1, 16'h9EF1, 4'hF, 4'hF);
      idle(2 * FRAME, 4'h0, 4'h0);
      // Partial enables and a single decimal point.
      step(1'b1, 1'b1, 16'h4321, 4'b1010, 4'b0010);
      idle(2 * FRAME, 4'h0, 4'h0);
      // Freeze during slot 2.
      while ((pos / DIV) % 4 != 2 || pos % DIV != 1) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
      idle(2 * FRAME, 4'h0, 4'h0);
      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) begin
            #2 reset = 1'b0;
            #1;
            check("async_anode", 32'(ssd_anode), 32'hF);
            check("async_pending", 32'(bus.pending), 32'h0);
            model_reset();
            @(negedge clk);
            reset = 1'b1;
         end
         step($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, 16'($urandom),
              4'($urandom), 4'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Consumer end of the seven-segment cathode path that the microwave/lab FSMs drive.
- Takes four hex digits from a producer and time-multiplexes them onto the board's shared cathode bus and 4 active-low anodes.
- Includes a tear-free load handshake, so the producer can update the digits at any time without corrupting a scan frame.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2 to 2^24-1.
- BLINK_DIV, 50000000: clk cycles per blink half-period; used only when SSD_BLINK_EN is defined.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  1 = scan; 0 = freeze scan and blank the display
- digits  input  16  hex digit values; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- digit_en  input  4  per-digit enable; 0 = that digit is blanked
- dp_in  input  4  per-digit decimal point; 1 = lit
- load  input  1  single-cycle strobe; captures digits, digit_en and dp_in into the shadow register
- blink_mask  input  4  per-digit blink select; present only with SSD_BLINK_EN
- ssd_cathode  output  7  active-low segments; bit 6 = a ... bit 0 = g
- ssd_dp  output  1  active-low decimal point
- ssd_anode  output  4  active-low digit select, one-hot; bit i = digit i
- pending  output  1  shadow holds data not yet applied to the display
- frame_tick  output  1  one-cycle pulse when a scan frame completes

Behaviour:
- Reset (async assert, sync release) sets:
  - ssd_cathode = 7'b1111111, ssd_dp = 1, ssd_anode = 4'b1111
  - pending = 0, frame_tick = 0
  - refresh counter = 0, digit index = 0
  - active and shadow registers = 0
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 while enable = 1.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Output timing:
  - All outputs are registered.
  - Anode and cathode change on the cycle after terminal count.
  - Each digit is therefore driven for exactly REFRESH_DIV cycles.
- Anode drive: ssd_anode = ~(4'b0001 << index) when the indexed digit is enabled and enable = 1; otherwise 4'b1111.
- Hex decode, active-low:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110
  - 4 → 1001100, 5 → 0100100, 6 → 0100000, 7 → 0001111
  - 8 → 0000000, 9 → 0000100, A → 0001000, b → 1100000
  - C → 0110001, d → 1000010, E → 0110000, F → 0111000
  - A blanked digit drives 1111111 and dp = 1.
- Load handshake:
  - load = 1 captures all three inputs into the shadow register and sets pending.
  - The shadow is copied to active only at a frame boundary: terminal count while index = 3. That same cycle clears pending and pulses frame_tick.
  - Repeated loads within one frame: the last one wins.
- Load coincident with a frame boundary:
  - Active receives the old shadow.
  - The shadow captures the new data and pending remains 1, so the new data is applied at the next boundary.
- Boundary with pending = 0: active is unchanged; frame_tick still pulses.
- enable = 0:
  - Counter and index hold their values.
  - Outputs are blanked on the next cycle: anode 1111, cathode 1111111, dp 1.
  - No frame_tick is generated.
  - Load still captures into the shadow.
- Re-enable: scanning resumes from the held counter and index, with no skipped or repeated slot.
- Reset mid-frame: immediate blank, all state cleared, pending lost.

Optional Feature:
- Macro: SSD_BLINK_EN.
- When defined:
  - Adds the blink_mask input, registered through the shadow/active path alongside digits.
  - A free-running blink counter toggles a phase bit every BLINK_DIV cycles; the phase resets to 1 (visible).
  - While phase = 0, digits whose mask bit is 1 are blanked.
  - The blink counter runs regardless of enable.
- When undefined: no blink_mask port, no blink counter; all enabled digits are always visible.

Test Plan:
- Reset released, REFRESH_DIV=4, load digits=16'h3210, digit_en=4'hF → after the first boundary the anode sequence is 1110, 1101, 1011, 0111, 4 cycles each. Cathode is 0000001, 1001111, 0010010, 0000110 respectively.
- load 16'hABCD mid-frame at index 1 → pending=1; digits 1–3 still show 1,2,3 for the rest of the frame. At the boundary: frame_tick=1, pending=0, and the next frame shows D,C,B,A.
- load asserted exactly at a boundary cycle → the old shadow is displayed and pending stays 1. The new value appears one frame later.
- digit_en=4'b1010, dp_in=4'b0010 → slots 0 and 2 show anode 1111 and cathode 1111111. Slot 1 shows ssd_dp=0.
- enable dropped during index 2 for 10 cycles → outputs blank, no frame_tick. On re-enable, index 2 resumes with the remaining count.
- SSD_BLINK_EN, BLINK_DIV=8, blink_mask=4'b0001 → digit 0 is visible for 8 cycles then blank for 8, repeating; digits 1–3 are unaffected.
